wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/cpu_pkg.sv | 18 +
 rtl/wb_slot.sv | 39 +++
 rtl/wb_arbiter.sv | 119 +++++++++++
 tb/tb_wb_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: requester identities, architectural register count
// and the one-hot register decode used for pending-register tracking.
package cpu_pkg;

  localparam int unsigned NUM_REGS = 32;

  typedef enum logic {
    REQ_EX = 1'b0,
    REQ_LD = 1'b1
  } req_id_e;

  function automatic logic [NUM_REGS-1:0] regno_onehot(input logic [4:0] regno);
    logic [NUM_REGS-1:0] one;
    one = {{(NUM_REGS-1){1'b0}}, 1'b1};
    return one << regno;
  endfunction

endpackage

// File: rtl/wb_slot.sv
// Single-entry writeback holding register; a fill in the same cycle as a
// drain wins, so a granted slot can be refilled back-to-back.
module wb_slot #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_fill,
  input  logic            i_drain,
  input  logic [4:0]      i_regno,
  input  logic [XLEN-1:0] i_data,
  output logic            o_valid,
  output logic [4:0]      o_regno,
  output logic [XLEN-1:0] o_data
);

  logic            r_valid;
  logic [4:0]      r_regno;
  logic [XLEN-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_regno <= '0;
      r_data  <= '0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_regno <= i_regno;
      r_data  <= i_data;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_regno = r_regno;
  assign o_data  = r_data;

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester register-file writeback arbiter: one buffer per requester,
// round-robin between distinct registers, oldest-first on the same register.
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [4:0]          ex_regno,
  input  logic [XLEN-1:0]     ex_data,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [4:0]          ld_regno,
  input  logic [XLEN-1:0]     ld_data,
  output logic                rf_write,
  output logic [5:0]          rf_regno_w,
  output logic [XLEN-1:0]     rf_data_w,
  output logic [NUM_REGS-1:0] pend_mask
);

  logic            w_ex_fill, w_ld_fill;
  logic            w_ex_valid, w_ld_valid;
  logic [4:0]      w_ex_regno, w_ld_regno;
  logic [XLEN-1:0] w_ex_data, w_ld_data;
  logic            w_gnt_ex, w_gnt_ld, w_age_grant;

  req_id_e r_last_grant;
  logic    r_ld_older;

  wb_slot #(.XLEN(XLEN)) u_ex_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_fill  (w_ex_fill),
    .i_drain (w_gnt_ex),
    .i_regno (ex_regno),
    .i_data  (ex_data),
    .o_valid (w_ex_valid),
    .o_regno (w_ex_regno),
    .o_data  (w_ex_data)
  );

  wb_slot #(.XLEN(XLEN)) u_ld_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_fill  (w_ld_fill),
    .i_drain (w_gnt_ld),
    .i_regno (ld_regno),
    .i_data  (ld_data),
    .o_valid (w_ld_valid),
    .o_regno (w_ld_regno),
    .o_data  (w_ld_data)
  );

  always_comb begin
    w_gnt_ex    = 1'b0;
    w_gnt_ld    = 1'b0;
    w_age_grant = 1'b0;
    if (w_ex_valid && w_ld_valid) begin
      if (w_ex_regno == w_ld_regno) begin
        w_age_grant = 1'b1;
        w_gnt_ld    = r_ld_older;
        w_gnt_ex    = !r_ld_older;
      end else begin
        w_gnt_ex = (r_last_grant == REQ_LD);
        w_gnt_ld = (r_last_grant == REQ_EX);
      end
    end else begin
      w_gnt_ex = w_ex_valid;
      w_gnt_ld = w_ld_valid;
    end
  end

  assign ex_ready  = !w_ex_valid || w_gnt_ex;
  assign ld_ready  = !w_ld_valid || w_gnt_ld;
  // Writes to r0 complete the handshake but never occupy a buffer.
  assign w_ex_fill = ex_valid && ex_ready && (ex_regno != '0);
  assign w_ld_fill = ld_valid && ld_ready && (ld_regno != '0);

  assign pend_mask = ({NUM_REGS{w_ex_valid}} & regno_onehot(w_ex_regno)) |
                     ({NUM_REGS{w_ld_valid}} & regno_onehot(w_ld_regno));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= REQ_LD;
      r_ld_older   <= 1'b0;
    end else begin
      if ((w_gnt_ex || w_gnt_ld) && !w_age_grant)
        r_last_grant <= w_gnt_ld ? REQ_LD : REQ_EX;
      // Age only matters while both slots hold entries; simultaneous fills make ld older.
      if (w_ex_fill && w_ld_fill)
        r_ld_older <= 1'b1;
      else if (w_ex_fill && w_ld_valid && !w_gnt_ld)
        r_ld_older <= 1'b1;
      else if (w_ld_fill && w_ex_valid && !w_gnt_ex)
        r_ld_older <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write   <= 1'b0;
      rf_regno_w <= '0;
      rf_data_w  <= '0;
    end else begin
      rf_write <= w_gnt_ex || w_gnt_ld;
      if (w_gnt_ex) begin
        rf_regno_w <= {1'b0, w_ex_regno};
        rf_data_w  <= w_ex_data;
      end else if (w_gnt_ld) begin
        rf_regno_w <= {1'b0, w_ld_regno};
        rf_data_w  <= w_ld_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, checked each
// cycle against a timestamp-based arbitration reference model.
module tb_wb_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ex_valid, ld_valid;
  logic            ex_ready, ld_ready;
  logic [4:0]      ex_regno, ld_regno;
  logic [XLEN-1:0] ex_data, ld_data;
  logic            rf_write;
  logic [5:0]      rf_regno_w;
  logic [XLEN-1:0] rf_data_w;
  logic [31:0]     pend_mask;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_regno   (ex_regno),
    .ex_data    (ex_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_regno   (ld_regno),
    .ld_data    (ld_data),
    .rf_write   (rf_write),
    .rf_regno_w (rf_regno_w),
    .rf_data_w  (rf_data_w),
    .pend_mask  (pend_mask)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: buffers carry arrival stamps; lower stamp is older.
  bit          m_ex_v, m_ld_v;
  logic [4:0]  m_ex_r, m_ld_r;
  logic [31:0] m_ex_d, m_ld_d;
  int          m_ex_t, m_ld_t;
  int          m_last;
  bit          m_we;
  logic [5:0]  m_rr;
  logic [31:0] m_rd;
  int          cyc = 0;
  int          m_ex_wr, m_ld_wr, d_ex_wr, d_ld_wr;
  logic [31:0] m_mem [32];
  logic [31:0] d_mem [32];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ex_v = 1'b0;
    m_ld_v = 1'b0;
    m_last = 1;
    m_we   = 1'b0;
    m_rr   = '0;
    m_rd   = '0;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_regno = '0; ex_data = '0;
    ld_valid = 1'b0; ld_regno = '0; ld_data = '0;
  endtask

  // Entered at a negedge with rf outputs settled; returns at the next negedge.
  task automatic do_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_rf_write", 64'(rf_write), 64'(0));
    chk("rst_rf_regno", 64'(rf_regno_w), 64'(0));
    chk("rst_rf_data", 64'(rf_data_w), 64'(0));
    chk("rst_ex_ready", 64'(ex_ready), 64'(1));
    chk("rst_ld_ready", 64'(ld_ready), 64'(1));
    chk("rst_pend_mask", 64'(pend_mask), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle(input bit ev, input logic [4:0] er, input logic [31:0] ed,
                       input bit lv, input logic [4:0] lr, input logic [31:0] ld);
    int          g;
    bit          age, ex_rdy, ld_rdy;
    logic [31:0] pm;
    ex_valid = ev; ex_regno = er; ex_data = ed;
    ld_valid = lv; ld_regno = lr; ld_data = ld;
    #1;
    g = -1;
    age = 1'b0;
    if (m_ex_v && m_ld_v) begin
      if (m_ex_r == m_ld_r) begin
        age = 1'b1;
        g = (m_ex_t < m_ld_t) ? 0 : 1;
      end else begin
        g = (m_last == 1) ? 0 : 1;
      end
    end else if (m_ex_v) g = 0;
    else if (m_ld_v) g = 1;
    ex_rdy = !m_ex_v || (g == 0);
    ld_rdy = !m_ld_v || (g == 1);
    pm = '0;
    if (m_ex_v) pm[m_ex_r] = 1'b1;
    if (m_ld_v) pm[m_ld_r] = 1'b1;
    chk("ex_ready", 64'(ex_ready), 64'(ex_rdy));
    chk("ld_ready", 64'(ld_ready), 64'(ld_rdy));
    chk("pend_mask", 64'(pend_mask), 64'(pm));
    @(posedge clk);
    m_we = (g >= 0);
    if (g == 0) begin
      m_rr = {1'b0, m_ex_r}; m_rd = m_ex_d; m_mem[m_ex_r] = m_ex_d;
      m_ex_v = 1'b0; m_ex_wr++;
    end else if (g == 1) begin
      m_rr = {1'b0, m_ld_r}; m_rd = m_ld_d; m_mem[m_ld_r] = m_ld_d;
      m_ld_v = 1'b0; m_ld_wr++;
    end
    if (g >= 0 && !age) m_last = g;
    if (ev && ex_rdy && er != 0) begin
      m_ex_v = 1'b1; m_ex_r = er; m_ex_d = ed; m_ex_t = 2 * cyc + 1;
    end
    if (lv && ld_rdy && lr != 0) begin
      m_ld_v = 1'b1; m_ld_r = lr; m_ld_d = ld; m_ld_t = 2 * cyc;
    end
    cyc++;
    @(negedge clk);
    chk("rf_write", 64'(rf_write), 64'(m_we));
    chk("rf_regno_w", 64'(rf_regno_w), 64'(m_rr));
    chk("rf_data_w", 64'(rf_data_w), 64'(m_rd));
    if (rf_write) begin
      d_mem[rf_regno_w[4:0]] = rf_data_w;
      if (rf_regno_w < 6'd16) d_ex_wr++;
      else d_ld_wr++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0;
      d_mem[i] = '0;
    end
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // Single ex write: rf_write two cycles after the accepting cycle.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    idle(4);
    chk("r5_value", 64'(d_mem[5]), 64'(32'hDEADBEEF));

    // Simultaneous distinct registers: ex wins first after reset.
    do_reset();
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    idle(4);
    chk("r3_value", 64'(d_mem[3]), 64'(32'h11));
    chk("r4_value", 64'(d_mem[4]), 64'(32'h22));

    // Same register, same cycle: ld is older, ex lands last.
    cycle(1'b1, 5'd7, 32'hBBBB, 1'b1, 5'd7, 32'hAAAA);
    idle(4);
    chk("r7_final", 64'(d_mem[7]), 64'(32'hBBBB));

    // Load to r0 is swallowed.
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
    idle(3);

    // Both requesters streaming to distinct registers.
    do_reset();
    m_ex_wr = 0; m_ld_wr = 0; d_ex_wr = 0; d_ld_wr = 0;
    for (int i = 0; i < 44; i++)
      cycle(1'b1, 5'(1 + (i % 15)), $urandom, 1'b1, 5'(16 + (i % 16)), $urandom);
    idle(4);
    chk("stream_ex_writes", 64'(d_ex_wr), 64'(m_ex_wr));
    chk("stream_ld_writes", 64'(d_ld_wr), 64'(m_ld_wr));
    chk("stream_ex_min20", 64'(d_ex_wr >= 20), 64'(1));
    chk("stream_ld_min20", 64'(d_ld_wr >= 20), 64'(1));

    // Random traffic over a small register set to force collisions and r0.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
    idle(4);
    for (int i = 0; i < 32; i++)
      chk($sformatf("mem_r%0d", i), 64'(d_mem[i]), 64'(m_mem[i]));

    // Reset with both buffers full and a write in flight.
    cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
    cycle(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0);
    chk("pre_rst_write", 64'(rf_write), 64'(1));
    do_reset();
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
